writeback_unit: RTL

- Write-side producer for the 16x32 register file. Sits in the WB stage.
- Arbitrates between the ALU result stream and the load-data stream, registers the winner, and drives the file's write port (write enable, destination register, write data).
- Keeps a pending-write scoreboard so decode can stall on RAW hazards. Drops writes to protected registers and flags them.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_arbiter.sv | 49 ++++
 rtl/writeback_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
// Optional macro WB_BYPASS_EN is consumed by writeback_unit.
package wb_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;
  localparam int SP_REG    = 14;
  localparam int PC_REG    = 15;

  localparam logic [NUM_REGS-1:0] DEFAULT_PROTECT_MASK =
    (NUM_REGS'(1) << SP_REG) | (NUM_REGS'(1) << PC_REG);

  typedef struct packed {
    logic [REG_IDX_W-1:0] dreg;
    logic [DATA_W-1:0]    data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD
  } wb_src_e;

endpackage

// File: rtl/wb_arbiter.sv
// Load-priority arbiter with an ALU anti-starvation counter.
// The ALU is forced through after MAX_WAIT consecutive losses.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    alu_valid,
  input  logic    ld_valid,
  output logic    alu_ready,
  output logic    ld_ready,
  output wb_src_e src
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;
  logic          alu_win;

  // Grant: loads first, unless the ALU has waited long enough
  always_comb begin
    alu_win   = alu_valid &&
                (!ld_valid || wait_cnt == WMAX);
    alu_ready = alu_win;
    ld_ready  = ld_valid && !alu_win;
    src       = SRC_NONE;
    unique case (1'b1)
      alu_ready: src = SRC_ALU;
      ld_ready:  src = SRC_LD;
      default:   src = SRC_NONE;
    endcase
  end

  // Count consecutive ALU losses, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (alu_valid && !alu_win) begin
      if (wait_cnt != WMAX)
        wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// WB stage: arbitrates results, drives the RF write port, tracks RAW.
// Macro WB_BYPASS_EN adds a same-cycle forwarding port.
module writeback_unit
  import wb_pkg::*;
#(
  parameter logic [NUM_REGS-1:0] PROTECT_MASK = DEFAULT_PROTECT_MASK,
  parameter int                  MAX_WAIT     = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_dreg,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_IDX_W-1:0] ld_dreg,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 alloc_valid,
  input  logic [REG_IDX_W-1:0] alloc_dreg,
`ifdef WB_BYPASS_EN
  input  logic [REG_IDX_W-1:0] byp_rreg,
  output logic                 byp_hit,
  output logic [DATA_W-1:0]    byp_data,
`endif
  output logic                 wr_en,
  output logic [REG_IDX_W-1:0] wr_dreg,
  output logic [DATA_W-1:0]    wr_data,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic                 prot_err
);

  wb_src_e               src;
  wb_req_t               req;
  logic                  grant;
  logic                  prot;
  logic [NUM_REGS-1:0]   busy_nxt;

  wb_arbiter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .ld_valid  (ld_valid),
    .alu_ready (alu_ready),
    .ld_ready  (ld_ready),
    .src       (src)
  );

  // Select the granted request and classify it
  always_comb begin
    req   = '0;
    grant = 1'b0;
    unique case (src)
      SRC_ALU: begin
        req   = '{dreg: alu_dreg, data: alu_data};
        grant = 1'b1;
      end
      SRC_LD: begin
        req   = '{dreg: ld_dreg, data: ld_data};
        grant = 1'b1;
      end
      default: begin
        req   = '0;
        grant = 1'b0;
      end
    endcase
    prot = grant && PROTECT_MASK[req.dreg];
  end

  // Scoreboard: clear on accept, then set on alloc so set wins
  always_comb begin
    busy_nxt = busy_vec;
    if (grant)
      busy_nxt[req.dreg] = 1'b0;
    if (alloc_valid)
      busy_nxt[alloc_dreg] = 1'b1;
  end

  // Output register and scoreboard state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en    <= 1'b0;
      wr_dreg  <= '0;
      wr_data  <= '0;
      busy_vec <= '0;
      prot_err <= 1'b0;
    end else begin
      wr_en    <= grant && !prot;
      prot_err <= prot;
      busy_vec <= busy_nxt;
      if (grant) begin
        wr_dreg <= req.dreg;
        wr_data <= req.data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the value being written this cycle
  always_comb begin
    byp_hit  = wr_en && (wr_dreg == byp_rreg);
    byp_data = wr_data;
  end
`endif

endmodule
